// File: rtl/stack_mem_arbiter.sv
// ============================================================================
// Module   : stack_mem_arbiter
// Function : Arbitrates data-memory access between load/store and PUSH/POP,
//            owns the downward-growing stack pointer and its error flags.
//            Optional macro STACK_GUARD_EN blocks load/store into the stack.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module stack_mem_arbiter #(
   parameter int DATA_WIDTH  = 16,
   parameter int ADDR_WIDTH  = 16,
   parameter int STACK_BASE  = 31,
   parameter int STACK_DEPTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  LS_READ_REQ,
   input  logic                  LS_WRITE_REQ,
   input  logic [ADDR_WIDTH-1:0] LS_ADDR,
   input  logic [DATA_WIDTH-1:0] LS_WRITE_DATA,
   output logic [DATA_WIDTH-1:0] LS_READ_DATA,
   output logic                  LS_STALL,
   input  logic                  PUSH_REQ,
   input  logic [DATA_WIDTH-1:0] PUSH_DATA,
   input  logic                  POP_REQ,
   output logic [DATA_WIDTH-1:0] POP_DATA,
   output logic                  POP_VALID,
   input  logic                  ERR_CLEAR,
   output logic [ADDR_WIDTH-1:0] SP,
   output logic                  STACK_OVERFLOW,
   output logic                  STACK_UNDERFLOW,
   output logic                  MEMORY_WRITE_ENABLE,
   output logic                  MEMORY_READ_ENABLE,
   output logic [ADDR_WIDTH-1:0] MEMORY_ACCESS_ADDR,
   output logic [DATA_WIDTH-1:0] MEMORY_WRITE_DATA,
   input  logic [DATA_WIDTH-1:0] MEMORY_READ_DATA
`ifdef STACK_GUARD_EN
   ,
   output logic                  STACK_GUARD_FAULT
`endif
);

   localparam int CW = $clog2(STACK_DEPTH + 1);
   localparam logic [ADDR_WIDTH-1:0] c_STACK_HI = ADDR_WIDTH'(STACK_BASE);
   localparam logic [ADDR_WIDTH-1:0] c_STACK_LO = ADDR_WIDTH'(STACK_BASE - STACK_DEPTH + 1);
   localparam logic [CW-1:0]         c_DEPTH    = CW'(STACK_DEPTH);

   logic [ADDR_WIDTH-1:0] r_sp;
   logic [CW-1:0]         r_count;
   logic [DATA_WIDTH-1:0] r_pop_data;
   logic                  r_pop_valid;
   logic                  r_overflow;
   logic                  r_underflow;

   logic w_full, w_empty, w_push_only, w_pop_only, w_bypass;
   logic w_do_push, w_do_pop, w_stack_mem, w_ls_req, w_in_stack, w_guard_hit;

   assign w_full      = (r_count == c_DEPTH);
   assign w_empty     = (r_count == '0);
   assign w_push_only = PUSH_REQ & ~POP_REQ;
   assign w_pop_only  = POP_REQ & ~PUSH_REQ;
   assign w_bypass    = PUSH_REQ & POP_REQ;
   assign w_do_push   = w_push_only & ~w_full;
   assign w_do_pop    = w_pop_only & ~w_empty;
   assign w_stack_mem = w_do_push | w_do_pop;
   assign w_ls_req    = LS_READ_REQ | LS_WRITE_REQ;

`ifdef STACK_GUARD_EN
   assign w_in_stack  = (LS_ADDR >= c_STACK_LO) && (LS_ADDR <= c_STACK_HI);
`else
   assign w_in_stack  = 1'b0;
`endif
   // A guarded access is only a fault when it would actually have been granted
   assign w_guard_hit = w_ls_req & ~w_stack_mem & w_in_stack;

   always_comb begin
      MEMORY_WRITE_ENABLE = 1'b0;
      MEMORY_READ_ENABLE  = 1'b0;
      MEMORY_ACCESS_ADDR  = '0;
      MEMORY_WRITE_DATA   = '0;
      LS_READ_DATA        = '0;
      LS_STALL            = 1'b0;
      if (rst) begin
         LS_STALL = 1'b0;
      end else if (w_do_push) begin
         MEMORY_WRITE_ENABLE = 1'b1;
         MEMORY_ACCESS_ADDR  = r_sp;
         MEMORY_WRITE_DATA   = PUSH_DATA;
         LS_STALL            = w_ls_req;
      end else if (w_do_pop) begin
         MEMORY_READ_ENABLE  = 1'b1;
         MEMORY_ACCESS_ADDR  = r_sp + ADDR_WIDTH'(1);
         LS_STALL            = w_ls_req;
      end else if (w_ls_req && !w_guard_hit) begin
         MEMORY_ACCESS_ADDR = LS_ADDR;
         if (LS_WRITE_REQ) begin
            MEMORY_WRITE_ENABLE = 1'b1;
            MEMORY_WRITE_DATA   = LS_WRITE_DATA;
         end else begin
            MEMORY_READ_ENABLE  = 1'b1;
            LS_READ_DATA        = MEMORY_READ_DATA;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sp        <= c_STACK_HI;
         r_count     <= '0;
         r_pop_data  <= '0;
         r_pop_valid <= 1'b0;
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         r_pop_valid <= 1'b0;
         if (w_bypass) begin
            r_pop_data  <= PUSH_DATA;
            r_pop_valid <= 1'b1;
         end else if (w_do_pop) begin
            r_pop_data  <= MEMORY_READ_DATA;
            r_pop_valid <= 1'b1;
            r_sp        <= r_sp + ADDR_WIDTH'(1);
            r_count     <= r_count - CW'(1);
         end else if (w_do_push) begin
            r_sp        <= r_sp - ADDR_WIDTH'(1);
            r_count     <= r_count + CW'(1);
         end
         // New errors take precedence over a simultaneous clear
         r_overflow  <= (r_overflow  & ~ERR_CLEAR) | (w_push_only & w_full);
         r_underflow <= (r_underflow & ~ERR_CLEAR) | (w_pop_only & w_empty);
      end
   end

`ifdef STACK_GUARD_EN
   logic r_guard_fault;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_guard_fault <= 1'b0;
      else     r_guard_fault <= (r_guard_fault & ~ERR_CLEAR) | w_guard_hit;
   end
   assign STACK_GUARD_FAULT = r_guard_fault;
`endif

   assign SP              = r_sp;
   assign POP_DATA        = r_pop_data;
   assign POP_VALID       = r_pop_valid;
   assign STACK_OVERFLOW  = r_overflow;
   assign STACK_UNDERFLOW = r_underflow;

endmodule

`default_nettype wire

// File: tb/tb_stack_mem_arbiter.sv
// ============================================================================
// Module   : tb_stack_mem_arbiter
// Function : Directed self-checking bench for stack_mem_arbiter with a
//            simple combinational-read data memory model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_stack_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        ls_rd, ls_wr, push, pop, err_clr;
   logic [15:0] ls_addr, ls_wdata, push_data;
   logic [15:0] ls_rdata, pop_data, sp, mem_addr, mem_wdata, mem_rdata;
   logic        ls_stall, pop_valid, ovf, unf, mem_we, mem_re;
`ifdef STACK_GUARD_EN
   logic        guard_fault;
`endif

   int errors = 0;
   int checks = 0;

   logic [15:0] mem [0:255];

   always #5 clk = ~clk;

   always @(posedge clk) if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
   assign mem_rdata = mem[mem_addr[7:0]];

   stack_mem_arbiter dut (
      .clk(clk), .rst(rst),
      .LS_READ_REQ(ls_rd), .LS_WRITE_REQ(ls_wr), .LS_ADDR(ls_addr),
      .LS_WRITE_DATA(ls_wdata), .LS_READ_DATA(ls_rdata), .LS_STALL(ls_stall),
      .PUSH_REQ(push), .PUSH_DATA(push_data), .POP_REQ(pop),
      .POP_DATA(pop_data), .POP_VALID(pop_valid), .ERR_CLEAR(err_clr),
      .SP(sp), .STACK_OVERFLOW(ovf), .STACK_UNDERFLOW(unf),
      .MEMORY_WRITE_ENABLE(mem_we), .MEMORY_READ_ENABLE(mem_re),
      .MEMORY_ACCESS_ADDR(mem_addr), .MEMORY_WRITE_DATA(mem_wdata),
      .MEMORY_READ_DATA(mem_rdata)
`ifdef STACK_GUARD_EN
      , .STACK_GUARD_FAULT(guard_fault)
`endif
   );

   // Inputs change 1 time unit after the rising edge; combinational checks at +4
   task automatic idle();
      ls_rd = 0; ls_wr = 0; push = 0; pop = 0; err_clr = 0;
      ls_addr = 0; ls_wdata = 0; push_data = 0;
   endtask

   task automatic next_cycle();
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      idle();
      rst = 1;
      next_cycle();
      next_cycle();
      rst = 0;
   endtask

   task automatic do_push(input logic [15:0] d);
      idle(); push = 1; push_data = d;
      next_cycle();
      idle();
   endtask

   task automatic test_reset();
      idle();
      rst = 1; push = 1; push_data = 16'hFFFF;
      #4;
      checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_we got=%b exp=0", mem_we); end
      next_cycle();
      checks++; if (sp !== 16'd31) begin errors++; $display("FAIL reset_sp got=%0d exp=31", sp); end
      checks++; if ({pop_valid, ovf, unf} !== 3'b000) begin errors++; $display("FAIL reset_flags got=%b exp=000", {pop_valid, ovf, unf}); end
      checks++; if (pop_data !== 16'h0) begin errors++; $display("FAIL reset_pop_data got=%h exp=0000", pop_data); end
      rst = 0; idle();
   endtask

   task automatic test_push_pop();
      do_reset();
      idle(); push = 1; push_data = 16'hA1A1;
      #4;
      checks++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 16'd31, 16'hA1A1}) begin errors++; $display("FAIL push1_mem got we=%b a=%0d d=%h exp we=1 a=31 d=a1a1", mem_we, mem_addr, mem_wdata); end
      next_cycle();
      push_data = 16'hB2B2;
      #4;
      checks++; if ({mem_we, mem_addr} !== {1'b1, 16'd30}) begin errors++; $display("FAIL push2_mem got we=%b a=%0d exp we=1 a=30", mem_we, mem_addr); end
      next_cycle();
      idle();
      checks++; if (sp !== 16'd29) begin errors++; $display("FAIL push2_sp got=%0d exp=29", sp); end
      pop = 1;
      #4;
      checks++; if ({mem_re, mem_addr} !== {1'b1, 16'd30}) begin errors++; $display("FAIL pop_mem got re=%b a=%0d exp re=1 a=30", mem_re, mem_addr); end
      next_cycle();
      idle();
      checks++; if ({pop_valid, pop_data} !== {1'b1, 16'hB2B2}) begin errors++; $display("FAIL pop_data got v=%b d=%h exp v=1 d=b2b2", pop_valid, pop_data); end
      checks++; if (sp !== 16'd30) begin errors++; $display("FAIL pop_sp got=%0d exp=30", sp); end
      next_cycle();
      checks++; if (pop_valid !== 1'b0) begin errors++; $display("FAIL pop_valid_pulse got=%b exp=0", pop_valid); end
   endtask

   task automatic test_overflow();
      do_reset();
      for (int i = 0; i < 8; i++) do_push(16'h0100 + 16'(i));
      push = 1; push_data = 16'hDEAD; ls_rd = 1; ls_addr = 16'd31;
      #4;
      checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL ovf_no_write got=%b exp=0", mem_we); end
      checks++; if ({ls_stall, mem_re, ls_rdata} !== {1'b0, 1'b1, 16'h0100}) begin errors++; $display("FAIL ovf_ls_grant got st=%b re=%b d=%h exp st=0 re=1 d=0100", ls_stall, mem_re, ls_rdata); end
      next_cycle();
      idle();
      checks++; if ({ovf, sp} !== {1'b1, 16'd23}) begin errors++; $display("FAIL ovf_flag got f=%b sp=%0d exp f=1 sp=23", ovf, sp); end
      pop = 1;
      next_cycle();
      idle();
      checks++; if ({pop_valid, pop_data, sp, ovf} !== {1'b1, 16'h0107, 16'd24, 1'b1}) begin errors++; $display("FAIL ovf_pop got v=%b d=%h sp=%0d f=%b exp v=1 d=0107 sp=24 f=1", pop_valid, pop_data, sp, ovf); end
      err_clr = 1;
      next_cycle();
      idle();
      checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_clear got=%b exp=0", ovf); end
   endtask

   task automatic test_underflow();
      do_reset();
      ls_wr = 1; ls_addr = 16'd5; ls_wdata = 16'h5A5A;
      next_cycle();
      idle(); pop = 1; ls_rd = 1; ls_addr = 16'd5;
      #4;
      checks++; if ({ls_stall, mem_re, mem_addr, ls_rdata} !== {1'b0, 1'b1, 16'd5, 16'h5A5A}) begin errors++; $display("FAIL unf_ls got st=%b re=%b a=%0d d=%h exp st=0 re=1 a=5 d=5a5a", ls_stall, mem_re, mem_addr, ls_rdata); end
      next_cycle();
      idle();
      checks++; if ({pop_valid, unf, sp} !== {1'b0, 1'b1, 16'd31}) begin errors++; $display("FAIL unf_flag got v=%b f=%b sp=%0d exp v=0 f=1 sp=31", pop_valid, unf, sp); end
      pop = 1; err_clr = 1;
      next_cycle();
      idle();
      checks++; if (unf !== 1'b1) begin errors++; $display("FAIL unf_clear_collide got=%b exp=1", unf); end
      err_clr = 1;
      next_cycle();
      idle();
      checks++; if (unf !== 1'b0) begin errors++; $display("FAIL unf_clear got=%b exp=0", unf); end
   endtask

   task automatic test_back_to_back();
      do_reset();
      push = 1; push_data = 16'h1234; ls_wr = 1; ls_addr = 16'd5; ls_wdata = 16'h5555;
      #4;
      checks++; if ({ls_stall, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 16'd31, 16'h1234}) begin errors++; $display("FAIL arb_c1 got st=%b we=%b a=%0d d=%h exp st=1 we=1 a=31 d=1234", ls_stall, mem_we, mem_addr, mem_wdata); end
      next_cycle();
      push = 0;
      #4;
      checks++; if ({ls_stall, mem_we, mem_addr, mem_wdata} !== {1'b0, 1'b1, 16'd5, 16'h5555}) begin errors++; $display("FAIL arb_c2 got st=%b we=%b a=%0d d=%h exp st=0 we=1 a=5 d=5555", ls_stall, mem_we, mem_addr, mem_wdata); end
      next_cycle();
      idle();
      checks++; if ({mem[5], mem[31]} !== {16'h5555, 16'h1234}) begin errors++; $display("FAIL arb_mem got m5=%h m31=%h exp 5555 1234", mem[5], mem[31]); end
      ls_rd = 1; ls_wr = 1; ls_addr = 16'd6; ls_wdata = 16'h6666;
      #4;
      checks++; if ({mem_we, mem_re, ls_rdata} !== {1'b1, 1'b0, 16'h0}) begin errors++; $display("FAIL ls_both got we=%b re=%b d=%h exp we=1 re=0 d=0000", mem_we, mem_re, ls_rdata); end
      next_cycle();
      idle();
   endtask

   task automatic test_bypass();
      push = 1; pop = 1; push_data = 16'h7777;
      #4;
      checks++; if ({mem_we, mem_re} !== 2'b00) begin errors++; $display("FAIL byp_mem got we=%b re=%b exp 0 0", mem_we, mem_re); end
      next_cycle();
      idle();
      checks++; if ({pop_valid, pop_data, sp} !== {1'b1, 16'h7777, 16'd30}) begin errors++; $display("FAIL byp_data got v=%b d=%h sp=%0d exp v=1 d=7777 sp=30", pop_valid, pop_data, sp); end
      do_reset();
      push = 1; pop = 1; push_data = 16'h8888;
      next_cycle();
      idle();
      checks++; if ({pop_valid, pop_data, unf, ovf, sp} !== {1'b1, 16'h8888, 2'b00, 16'd31}) begin errors++; $display("FAIL byp_empty got v=%b d=%h u=%b o=%b sp=%0d exp v=1 d=8888 u=0 o=0 sp=31", pop_valid, pop_data, unf, ovf, sp); end
   endtask

   task automatic test_mid_reset();
      do_reset();
      do_push(16'h0001); do_push(16'h0002); do_push(16'h0003);
      pop = 1;
      next_cycle();
      idle();
      checks++; if ({pop_valid, pop_data} !== {1'b1, 16'h0003}) begin errors++; $display("FAIL mid_pop got v=%b d=%h exp v=1 d=0003", pop_valid, pop_data); end
      #1 rst = 1;
      #1;
      checks++; if ({sp, pop_valid, pop_data, ovf, unf} !== {16'd31, 1'b0, 16'h0, 2'b00}) begin errors++; $display("FAIL mid_reset got sp=%0d v=%b d=%h o=%b u=%b exp sp=31 v=0 d=0 o=0 u=0", sp, pop_valid, pop_data, ovf, unf); end
      next_cycle();
      rst = 0;
      pop = 1;
      next_cycle();
      idle();
      checks++; if ({unf, pop_valid} !== 2'b10) begin errors++; $display("FAIL mid_empty got u=%b v=%b exp u=1 v=0", unf, pop_valid); end
   endtask

`ifdef STACK_GUARD_EN
   task automatic test_guard();
      do_reset();
      ls_rd = 1; ls_addr = 16'd28;
      #4;
      checks++; if ({mem_re, mem_we, ls_stall, ls_rdata} !== {3'b000, 16'h0}) begin errors++; $display("FAIL guard_block got re=%b we=%b st=%b d=%h exp all 0", mem_re, mem_we, ls_stall, ls_rdata); end
      next_cycle();
      ls_addr = 16'd23;
      #4;
      checks++; if ({guard_fault, mem_re} !== 2'b11) begin errors++; $display("FAIL guard_fault got f=%b re=%b exp f=1 re=1", guard_fault, mem_re); end
      next_cycle();
      idle(); err_clr = 1;
      next_cycle();
      idle();
      checks++; if (guard_fault !== 1'b0) begin errors++; $display("FAIL guard_clear got=%b exp=0", guard_fault); end
   endtask
`endif

   initial begin
      test_reset();
      test_push_pop();
      test_overflow();
      test_underflow();
      test_back_to_back();
      test_bypass();
      test_mid_reset();
`ifdef STACK_GUARD_EN
      test_guard();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/stack_mem_arbiter.md
Name: stack_mem_arbiter

Overview:
- Sits directly upstream of the 16-bit data memory and is the only driver of its write-enable, read-enable, address and write-data inputs.
- Arbitrates between ordinary load/store requests from the execute stage and PUSH/POP stack operations.
- Maintains the stack pointer (SP) for a downward-growing stack in the top words of data memory, reports overflow/underflow, and returns popped data one cycle after the pop request.

Parameters:
- DATA_WIDTH, 16, memory word width.
- ADDR_WIDTH, 16, memory address width.
- STACK_BASE, 31, highest stack address; first push lands here.
- STACK_DEPTH, 8, maximum number of stacked words; stack occupies STACK_BASE-STACK_DEPTH+1 .. STACK_BASE.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- LS_READ_REQ  in  1  execute-stage load request.
- LS_WRITE_REQ  in  1  execute-stage store request.
- LS_ADDR  in  ADDR_WIDTH  load/store address.
- LS_WRITE_DATA  in  DATA_WIDTH  store data.
- LS_READ_DATA  out  DATA_WIDTH  load data (combinational).
- LS_STALL  out  1  load/store not granted this cycle; requester holds its request.
- PUSH_REQ  in  1  push PUSH_DATA.
- PUSH_DATA  in  DATA_WIDTH  word to push.
- POP_REQ  in  1  pop top of stack.
- POP_DATA  out  DATA_WIDTH  registered popped word.
- POP_VALID  out  1  one-cycle pulse; POP_DATA is valid.
- ERR_CLEAR  in  1  synchronous clear of sticky flags.
- SP  out  ADDR_WIDTH  next free stack address.
- STACK_OVERFLOW  out  1  sticky flag.
- STACK_UNDERFLOW  out  1  sticky flag.
- MEMORY_WRITE_ENABLE  out  1  to data memory.
- MEMORY_READ_ENABLE  out  1  to data memory.
- MEMORY_ACCESS_ADDR  out  ADDR_WIDTH  to data memory.
- MEMORY_WRITE_DATA  out  DATA_WIDTH  to data memory.
- MEMORY_READ_DATA  in  DATA_WIDTH  from data memory (combinational read).

Behaviour:
- Reset (async, rst=1):
  - SP=STACK_BASE; internal count=0.
  - POP_DATA=0, POP_VALID=0, STACK_OVERFLOW=0, STACK_UNDERFLOW=0.
  - All memory controls forced 0 while rst=1.
  - A push or pop in flight is discarded; stack is empty after reset.
- Registered state: SP, count (0..STACK_DEPTH), POP_DATA, POP_VALID, both flags. Memory-side outputs and LS_STALL are combinational from the current requests and state.
- Priority: stack operation > load/store. A stack op that uses memory asserts LS_STALL if LS_READ_REQ or LS_WRITE_REQ is high; the LS request is granted in the first cycle with no memory-using stack op.
- PUSH only, count<STACK_DEPTH:
  - Drives WE=1, ADDR=SP, WDATA=PUSH_DATA.
  - Next edge: SP-=1, count+=1.
- PUSH only, count==STACK_DEPTH:
  - No write; SP and count unchanged; STACK_OVERFLOW<=1.
  - Memory is free, so LS is granted.
- POP only, count>0:
  - Drives RE=1, ADDR=SP+1.
  - Next edge: POP_DATA<=MEMORY_READ_DATA, POP_VALID<=1, SP+=1, count-=1. Latency is 1 cycle.
- POP only, count==0:
  - No access; STACK_UNDERFLOW<=1; POP_VALID stays 0; POP_DATA holds.
  - LS is granted.
- PUSH and POP together:
  - Bypass: POP_DATA<=PUSH_DATA, POP_VALID<=1.
  - SP and count unchanged, no memory access, LS granted, no flag change. This applies even when the stack is empty or full.
- LS granted:
  - Store: WE=LS_WRITE_REQ, WDATA=LS_WRITE_DATA.
  - Load: RE=LS_READ_REQ, LS_READ_DATA=MEMORY_READ_DATA.
  - ADDR=LS_ADDR.
  - Both LS requests high: the store wins, RE=0, LS_READ_DATA=0.
- LS_READ_DATA=0 whenever no load is granted.
- POP_VALID is high for exactly one cycle per successful pop or bypass.
- Flags are sticky until ERR_CLEAR or rst. If ERR_CLEAR and a new error occur in the same cycle, the flag is set.
- SP arithmetic is ADDR_WIDTH wide. Count bounds guarantee SP stays within [STACK_BASE-STACK_DEPTH, STACK_BASE], so no wrap occurs.

Optional Feature:
- Macro: STACK_GUARD_EN.
- Defined:
  - An LS access with LS_ADDR inside the stack region (STACK_BASE-STACK_DEPTH+1 .. STACK_BASE) is blocked: WE=RE=0, LS_READ_DATA=0, LS_STALL=0. The request is consumed, not retried.
  - Output STACK_GUARD_FAULT (1 bit, sticky, cleared by rst or ERR_CLEAR) is set.
- Undefined: no range check is made and the STACK_GUARD_FAULT port is absent.

Test Plan:
- Reset, then push 0xA1A1, 0xB2B2 → writes at addr 31, 30; SP=29. Pop → next cycle POP_VALID=1, POP_DATA=0xB2B2, SP=30.
- 8 pushes then a 9th push with PUSH_DATA=0xDEAD → 9th has no write, STACK_OVERFLOW=1, SP=23. ERR_CLEAR → flag 0.
- Pop on empty stack → POP_VALID=0, STACK_UNDERFLOW=1, SP=31, LS_READ_REQ in the same cycle granted with LS_STALL=0.
- Push 0x1234 with LS_WRITE_REQ addr 5 data 0x5555 → cycle 1 LS_STALL=1 and mem write at 31; cycle 2 mem write 0x5555 at 5, LS_STALL=0.
- PUSH and POP together with PUSH_DATA=0x7777 → POP_DATA=0x7777, POP_VALID=1, SP unchanged, MEMORY_WRITE_ENABLE=0.
- rst asserted mid-stream after 3 pushes → SP=31, flags 0, POP_VALID=0 immediately. With STACK_GUARD_EN, a load at addr 28 → blocked, STACK_GUARD_FAULT=1.
